// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: the NOP used for IF/ID bubbles,
// the fetch FSM states and the IF/ID register operation encoding.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // One-hot-free encoding of what the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'b00,
        IFID_LOAD  = 2'b01,
        IFID_FLUSH = 2'b10
    } ifid_op_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: ROM fetch path, next-PC control from execute and the IF/ID outputs.
// master = fetch stage side, slave = surrounding pipeline/ROM side.
interface fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] instr_i;
    logic                  stall_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_target_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  valid_o;
    logic                  fault_o;
    logic                  misalign_o;

    modport master (
        output addr_o, instr_o, pc_o, valid_o, fault_o, misalign_o,
        input  instr_i, stall_i, redirect_i, redirect_target_i
    );

    modport slave (
        input  addr_o, instr_o, pc_o, valid_o, fault_o, misalign_o,
        output instr_i, stall_i, redirect_i, redirect_target_i
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction with its PC, hold it, or flush
// it to a NOP bubble (a flush keeps the last PC so pc_o only moves on real loads).
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ifid_op_t              op,
    input  logic [DATA_WIDTH-1:0] instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  valid
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr <= DATA_WIDTH'(NOP_INSTR);
            pc    <= '0;
            valid <= 1'b0;
        end else begin
            unique case (op)
                IFID_LOAD: begin
                    instr <= instr_d;
                    pc    <= pc_d;
                    valid <= 1'b1;
                end
                IFID_FLUSH: begin
                    instr <= DATA_WIDTH'(NOP_INSTR);
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Program counter and fetch control: drives the ROM address, handles stall/redirect
// and stops in FAULT on an out-of-range fetch. Define FETCH_MISALIGN_TRAP_EN to trap
// misaligned redirect targets instead of silently word-aligning them.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] FIRST_INSTR_ADDR = 32'hBFC0_0000,
    parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR  = 32'hBFC0_0FFF
) (
    input  logic  clk_i,
    input  logic  rst_i,
    fetch_if.master bus
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] target_eff;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] pc_cand;
    logic                  cand_legal;
    ifid_op_t              ifid_op;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
    logic                  target_misaligned;
`endif

    // Candidate next PC and its range check; the extra top bit keeps pc+3 from wrapping.
    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        target_misaligned = |bus.redirect_target_i[1:0];
        target_eff        = bus.redirect_target_i;
`else
        target_eff        = bus.redirect_target_i & ~DATA_WIDTH'(3);
`endif
        pc_inc     = pc_q + DATA_WIDTH'(4);
        pc_cand    = bus.redirect_i ? target_eff : pc_inc;
        cand_legal = ({1'b0, pc_cand} >= {1'b0, FIRST_INSTR_ADDR}) &&
                     ({1'b0, pc_cand} + (DATA_WIDTH+1)'(3) <= {1'b0, LAST_INSTR_ADDR});
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= FIRST_INSTR_ADDR;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Next-state logic: redirect beats stall; an illegal candidate freezes the PC.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (state_q == RUN) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_i && target_misaligned) begin
                state_d    = FAULT;
                misalign_d = 1'b1;
            end else
`endif
            if (bus.redirect_i || !bus.stall_i) begin
                if (cand_legal) pc_d = pc_cand;
                else            state_d = FAULT;
            end
        end
    end

    // Output logic. An advance into an illegal PC still loads the current word.
    always_comb begin
        ifid_op = IFID_HOLD;
        if (state_q == FAULT || bus.redirect_i) ifid_op = IFID_FLUSH;
        else if (!bus.stall_i)                  ifid_op = IFID_LOAD;
    end

    assign bus.addr_o     = pc_q;
    assign bus.fault_o    = (state_q == FAULT);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign_o = misalign_q;
`else
    assign bus.misalign_o = 1'b0;
`endif

    if_id_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op      (ifid_op),
        .instr_d (bus.instr_i),
        .pc_d    (pc_q),
        .instr   (bus.instr_o),
        .pc      (bus.pc_o),
        .valid   (bus.valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural PC model plus a scoreboard queue of
// expected IF/ID entries pushed when an advance is driven and popped when it appears.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] FIRST = 32'hBFC0_0000;
    localparam logic [31:0] LAST  = 32'hBFC0_0FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_if #(.DATA_WIDTH(32)) bus ();

    fetch_stage #(
        .DATA_WIDTH       (32),
        .FIRST_INSTR_ADDR (FIRST),
        .LAST_INSTR_ADDR  (LAST)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.instr_i = rom(bus.addr_o);

    int          checks = 0;
    int          errors = 0;
    ifid_t       sb_q[$];
    ifid_t       held;
    logic [31:0] m_pc;
    bit          m_fault, m_misalign, m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        logic [63:0] w;
        w = {32'b0, a};
        return (w >= {32'b0, FIRST}) && (w + 64'd3 <= {32'b0, LAST});
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, "_addr"},     bus.addr_o,           m_pc);
        check({tag, "_fault"},    32'(bus.fault_o),     32'(m_fault));
        check({tag, "_misalign"}, 32'(bus.misalign_o),  32'(m_misalign));
        check({tag, "_valid"},    32'(bus.valid_o),     32'(m_valid));
        check({tag, "_pc_o"},     bus.pc_o,             held.pc);
        check({tag, "_instr"},    bus.instr_o,          m_valid ? held.instr : NOP_INSTR);
    endtask

    // Drive one cycle of stimulus, update the model, then compare just after the edge.
    task automatic cycle(input string tag, input bit s, input bit r, input logic [31:0] t);
        bit          adv;
        logic [31:0] tgt;
        bus.stall_i           = s;
        bus.redirect_i        = r;
        bus.redirect_target_i = t;
        adv = 1'b0;
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (r) begin
            m_valid = 1'b0;
            tgt     = TRAP ? t : {t[31:2], 2'b00};
            if (TRAP && t[1:0] != 2'b00) begin
                m_fault    = 1'b1;
                m_misalign = 1'b1;
            end else if (legal(tgt)) begin
                m_pc = tgt;
            end else begin
                m_fault = 1'b1;
            end
        end else if (!s) begin
            sb_q.push_back('{instr: rom(m_pc), pc: m_pc});
            adv     = 1'b1;
            m_valid = 1'b1;
            if (legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
            else                     m_fault = 1'b1;
        end
        @(posedge clk);
        #1;
        if (adv) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_sb scoreboard empty", tag);
            end else begin
                held = sb_q.pop_front();
            end
        end
        compare_outputs(tag);
    endtask

    task automatic do_reset();
        rst                   = 1'b1;
        bus.stall_i           = 1'b0;
        bus.redirect_i        = 1'b1;
        bus.redirect_target_i = 32'hBFC0_0200;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        m_pc       = FIRST;
        m_fault    = 1'b0;
        m_misalign = 1'b0;
        m_valid    = 1'b0;
        held       = '{instr: NOP_INSTR, pc: 32'h0};
        sb_q.delete();
        compare_outputs("reset");
        check("reset_addr_const", bus.addr_o, 32'hBFC0_0000);
    endtask

    initial begin
        bus.stall_i           = 1'b0;
        bus.redirect_i        = 1'b0;
        bus.redirect_target_i = 32'h0;
        do_reset();

        // Free-running fetch from reset
        cycle("t1_c1", 1'b0, 1'b0, 32'h0);
        check("t1_c1_pc_const", bus.pc_o, 32'hBFC0_0000);
        cycle("t1_c2", 1'b0, 1'b0, 32'h0);
        cycle("t1_c3", 1'b0, 1'b0, 32'h0);
        check("t1_c3_addr_const", bus.addr_o, 32'hBFC0_000C);
        cycle("t2_pre", 1'b0, 1'b0, 32'h0);
        check("t2_pre_addr_const", bus.addr_o, 32'hBFC0_0010);

        // Stall holds everything
        cycle("t2_s1", 1'b1, 1'b0, 32'h0);
        cycle("t2_s2", 1'b1, 1'b0, 32'h0);
        check("t2_addr_const", bus.addr_o, 32'hBFC0_0010);
        cycle("t2_go", 1'b0, 1'b0, 32'h0);

        // Redirect wins over stall
        cycle("t3_redir", 1'b1, 1'b1, 32'hBFC0_0100);
        check("t3_addr_const", bus.addr_o, 32'hBFC0_0100);
        cycle("t3_r1", 1'b0, 1'b0, 32'h0);
        cycle("t3_r2", 1'b0, 1'b0, 32'h0);

        // Last legal word is delivered, then FAULT
        cycle("t4_redir", 1'b0, 1'b1, 32'hBFC0_0FFC);
        cycle("t4_last", 1'b0, 1'b0, 32'h0);
        check("t4_last_pc_const", bus.pc_o, 32'hBFC0_0FFC);
        cycle("t4_fault", 1'b0, 1'b0, 32'h0);
        check("t4_fault_const", 32'(bus.fault_o), 32'd1);
        cycle("t4_ign", 1'b1, 1'b1, 32'hBFC0_0100);

        // Redirect to 0 faults; everything ignored until reset
        do_reset();
        cycle("t5_redir0", 1'b0, 1'b1, 32'h0000_0000);
        cycle("t5_ign_r", 1'b0, 1'b1, 32'hBFC0_0100);
        cycle("t5_ign_s", 1'b1, 1'b0, 32'h0);
        cycle("t5_ign_a", 1'b0, 1'b0, 32'h0);
        do_reset();

        // Range boundaries on redirect
        cycle("b_below", 1'b0, 1'b1, 32'hBFBF_FFFC);
        do_reset();
        cycle("b_above", 1'b0, 1'b1, 32'hBFC0_1000);
        do_reset();
        cycle("b_wrap", 1'b0, 1'b1, 32'hFFFF_FFFC);
        do_reset();

        // Misaligned redirect
        cycle("t6_mis", 1'b0, 1'b1, 32'hBFC0_0102);
        check("t6_addr_const", bus.addr_o, TRAP ? 32'hBFC0_0000 : 32'hBFC0_0100);
        cycle("t6_next", 1'b0, 1'b0, 32'h0);
        do_reset();

        // Mixed random traffic, targets mostly inside the ROM window
        for (int i = 0; i < 80; i++) begin
            bit          s, r;
            logic [31:0] t;
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = FIRST + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 9) == 0) t = t | 32'($urandom_range(1, 3));
            cycle("rnd", s, r, t);
            if (m_fault && $urandom_range(0, 2) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
